// File: rtl/xbar_arb2.sv
// Two-master TileLink-UL arbiter: round-robin on Channel A, one transaction in flight,
// Channel D routed back to the owning master only.
module xbar_arb2 #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned PARAM_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  // master 0
  input  logic                    m0_a_valid,
  output logic                    m0_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m0_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m0_a_param,
  input  logic [SIZE_WIDTH-1:0]   m0_a_size,
  input  logic [ADDR_WIDTH-1:0]   m0_a_address,
  input  logic [MASK_WIDTH-1:0]   m0_a_mask,
  input  logic [DATA_WIDTH-1:0]   m0_a_data,
  output logic                    m0_d_valid,
  input  logic                    m0_d_ready,
  output logic [OPCODE_WIDTH-1:0] m0_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m0_d_param,
  output logic [SIZE_WIDTH-1:0]   m0_d_size,
  output logic                    m0_d_source,
  output logic                    m0_d_sink,
  output logic                    m0_d_error,
  output logic [DATA_WIDTH-1:0]   m0_d_data,
  // master 1
  input  logic                    m1_a_valid,
  output logic                    m1_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m1_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m1_a_param,
  input  logic [SIZE_WIDTH-1:0]   m1_a_size,
  input  logic [ADDR_WIDTH-1:0]   m1_a_address,
  input  logic [MASK_WIDTH-1:0]   m1_a_mask,
  input  logic [DATA_WIDTH-1:0]   m1_a_data,
  output logic                    m1_d_valid,
  input  logic                    m1_d_ready,
  output logic [OPCODE_WIDTH-1:0] m1_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m1_d_param,
  output logic [SIZE_WIDTH-1:0]   m1_d_size,
  output logic                    m1_d_source,
  output logic                    m1_d_sink,
  output logic                    m1_d_error,
  output logic [DATA_WIDTH-1:0]   m1_d_data,
  // downstream slave port
  output logic                    s_a_valid,
  input  logic                    s_a_ready,
  output logic [OPCODE_WIDTH-1:0] s_a_opcode,
  output logic [PARAM_WIDTH-1:0]  s_a_param,
  output logic [SIZE_WIDTH-1:0]   s_a_size,
  output logic [ADDR_WIDTH-1:0]   s_a_address,
  output logic [MASK_WIDTH-1:0]   s_a_mask,
  output logic [DATA_WIDTH-1:0]   s_a_data,
  output logic                    s_a_source,
  input  logic                    s_d_valid,
  output logic                    s_d_ready,
  input  logic [OPCODE_WIDTH-1:0] s_d_opcode,
  input  logic [PARAM_WIDTH-1:0]  s_d_param,
  input  logic [SIZE_WIDTH-1:0]   s_d_size,
  input  logic                    s_d_source,
  input  logic                    s_d_sink,
  input  logic [DATA_WIDTH-1:0]   s_d_data,
  input  logic                    s_d_error
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitD} state_e;

  state_e state_q, state_d;
  logic   owner_q, prio_q, prio_d;
  logic   s_a_valid_q;
  logic   grant0, grant1, in_idle, in_wait, sel0, sel1, d_err;

  // Gating with reset keeps a_ready low while reset is held, not just after the next edge.
  assign in_idle = (state_q == StIdle) && reset;
  assign in_wait = (state_q == StWaitD);
  assign grant0  = in_idle && m0_a_valid && (!m1_a_valid || !prio_q);
  assign grant1  = in_idle && m1_a_valid && !grant0;

  assign m0_a_ready = grant0;
  assign m1_a_ready = grant1;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle:  if (grant0 || grant1) state_d = StIssue;
      StIssue: if (s_a_ready) state_d = StWaitD;
      StWaitD: begin
        if (s_d_valid && s_d_ready) begin
          prio_d  = ~owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      s_a_valid_q <= 1'b0;
      s_a_opcode  <= '0;
      s_a_param   <= '0;
      s_a_size    <= '0;
      s_a_address <= '0;
      s_a_mask    <= '0;
      s_a_data    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (grant0 || grant1) begin
        owner_q     <= grant1;
        s_a_valid_q <= 1'b1;
        s_a_opcode  <= grant1 ? m1_a_opcode  : m0_a_opcode;
        s_a_param   <= grant1 ? m1_a_param   : m0_a_param;
        s_a_size    <= grant1 ? m1_a_size    : m0_a_size;
        s_a_address <= grant1 ? m1_a_address : m0_a_address;
        s_a_mask    <= grant1 ? m1_a_mask    : m0_a_mask;
        s_a_data    <= grant1 ? m1_a_data    : m0_a_data;
      end else if (state_q == StIssue && s_a_ready) begin
        s_a_valid_q <= 1'b0;
      end
    end
  end

  assign s_a_valid  = s_a_valid_q;
  assign s_a_source = owner_q;

  // A response tagged with the wrong source is still delivered, but flagged as an error.
  assign d_err     = s_d_error | (s_d_source != owner_q);
  assign sel0      = in_wait && !owner_q;
  assign sel1      = in_wait && owner_q;
  assign s_d_ready = in_wait && (owner_q ? m1_d_ready : m0_d_ready);

  assign m0_d_valid  = sel0 & s_d_valid;
  assign m0_d_opcode = sel0 ? s_d_opcode : '0;
  assign m0_d_param  = sel0 ? s_d_param  : '0;
  assign m0_d_size   = sel0 ? s_d_size   : '0;
  assign m0_d_source = sel0 & s_d_source;
  assign m0_d_sink   = sel0 & s_d_sink;
  assign m0_d_error  = sel0 & d_err;
  assign m0_d_data   = sel0 ? s_d_data   : '0;

  assign m1_d_valid  = sel1 & s_d_valid;
  assign m1_d_opcode = sel1 ? s_d_opcode : '0;
  assign m1_d_param  = sel1 ? s_d_param  : '0;
  assign m1_d_size   = sel1 ? s_d_size   : '0;
  assign m1_d_source = sel1 & s_d_source;
  assign m1_d_sink   = sel1 & s_d_sink;
  assign m1_d_error  = sel1 & d_err;
  assign m1_d_data   = sel1 ? s_d_data   : '0;

endmodule

// File: tb/tb_xbar_arb2.sv
// Directed bench for xbar_arb2: expected A beats and D data go through scoreboard queues
// and are checked when the DUT presents them.
module tb_xbar_arb2;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
  logic [2:0]  m0_a_opcode, m0_a_param, m0_a_size, m1_a_opcode, m1_a_param, m1_a_size;
  logic [31:0] m0_a_address, m0_a_data, m1_a_address, m1_a_data;
  logic [3:0]  m0_a_mask, m1_a_mask;
  logic        m0_d_valid, m0_d_ready, m0_d_source, m0_d_sink, m0_d_error;
  logic        m1_d_valid, m1_d_ready, m1_d_source, m1_d_sink, m1_d_error;
  logic [2:0]  m0_d_opcode, m0_d_param, m0_d_size, m1_d_opcode, m1_d_param, m1_d_size;
  logic [31:0] m0_d_data, m1_d_data;
  logic        s_a_valid, s_a_ready, s_a_source;
  logic [2:0]  s_a_opcode, s_a_param, s_a_size;
  logic [31:0] s_a_address, s_a_data;
  logic [3:0]  s_a_mask;
  logic        s_d_valid, s_d_ready, s_d_source, s_d_sink, s_d_error;
  logic [2:0]  s_d_opcode, s_d_param, s_d_size;
  logic [31:0] s_d_data;

  xbar_arb2 dut (
    .clk(clk), .reset(reset),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_address(m0_a_address),
    .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
    .m0_d_sink(m0_d_sink), .m0_d_error(m0_d_error), .m0_d_data(m0_d_data),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_address(m1_a_address),
    .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
    .m1_d_sink(m1_d_sink), .m1_d_error(m1_d_error), .m1_d_data(m1_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_address(s_a_address),
    .s_a_mask(s_a_mask), .s_a_data(s_a_data), .s_a_source(s_a_source),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_sink(s_d_sink), .s_d_data(s_d_data), .s_d_error(s_d_error)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        src;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       a_q[$];
  logic [31:0] d_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic push_a(input logic src, input logic [31:0] addr, input logic [31:0] data);
    beat_t b;
    b.src  = src;
    b.addr = addr;
    b.data = data;
    a_q.push_back(b);
  endtask

  task automatic drv_m(input logic idx, input logic v, input logic [31:0] addr,
                       input logic [31:0] data);
    if (idx) begin
      m1_a_valid = v; m1_a_address = addr; m1_a_data = data;
    end else begin
      m0_a_valid = v; m0_a_address = addr; m0_a_data = data;
    end
  endtask

  task automatic drv_d(input logic src, input logic err, input logic [31:0] data);
    s_d_valid = 1'b1; s_d_source = src; s_d_error = err; s_d_data = data;
    d_q.push_back(data);
  endtask

  // Expects an A beat being transferred this cycle.
  task automatic check_a(input string tag);
    beat_t e;
    chk({tag, "_valid"}, 64'(s_a_valid), 64'd1);
    chk({tag, "_sb_nonempty"}, 64'(a_q.size() != 0), 64'd1);
    if (a_q.size() != 0) begin
      e = a_q.pop_front();
      chk({tag, "_source"}, 64'(s_a_source), 64'(e.src));
      chk({tag, "_addr"}, 64'(s_a_address), 64'(e.addr));
      chk({tag, "_data"}, 64'(s_a_data), 64'(e.data));
      chk({tag, "_mask"}, 64'(s_a_mask), 64'hf);
    end
  endtask

  task automatic check_d(input logic idx, input string tag, input logic err);
    logic [31:0] want;
    chk({tag, "_sb_nonempty"}, 64'(d_q.size() != 0), 64'd1);
    want = (d_q.size() != 0) ? d_q.pop_front() : 32'hx;
    chk({tag, "_valid"}, 64'(idx ? m1_d_valid : m0_d_valid), 64'd1);
    chk({tag, "_data"}, 64'(idx ? m1_d_data : m0_d_data), 64'(want));
    chk({tag, "_error"}, 64'(idx ? m1_d_error : m0_d_error), 64'(err));
    chk({tag, "_opcode"}, 64'(idx ? m1_d_opcode : m0_d_opcode), 64'd1);
    chk({tag, "_other_valid"}, 64'(idx ? m0_d_valid : m1_d_valid), 64'd0);
    chk({tag, "_other_data"}, 64'(idx ? m0_d_data : m1_d_data), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    m0_a_valid = 1'b0; m0_a_opcode = 3'd4; m0_a_param = '0; m0_a_size = 3'd2;
    m0_a_address = '0; m0_a_mask = 4'hf; m0_a_data = '0; m0_d_ready = 1'b1;
    m1_a_valid = 1'b0; m1_a_opcode = 3'd4; m1_a_param = '0; m1_a_size = 3'd2;
    m1_a_address = '0; m1_a_mask = 4'hf; m1_a_data = '0; m1_d_ready = 1'b1;
    s_a_ready = 1'b1;
    s_d_valid = 1'b0; s_d_opcode = 3'd1; s_d_param = '0; s_d_size = 3'd2;
    s_d_source = 1'b0; s_d_sink = 1'b0; s_d_data = '0; s_d_error = 1'b0;

    // Reset state, with requests and a response pending to prove they are masked.
    #11;
    m0_a_valid = 1'b1; s_d_valid = 1'b1; s_d_data = 32'h1111;
    #1;
    chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
    chk("rst_s_a_addr", 64'(s_a_address), 64'd0);
    chk("rst_m0_a_ready", 64'(m0_a_ready), 64'd0);
    chk("rst_s_d_ready", 64'(s_d_ready), 64'd0);
    chk("rst_m0_d_valid", 64'(m0_d_valid), 64'd0);
    chk("rst_m0_d_data", 64'(m0_d_data), 64'd0);
    m0_a_valid = 1'b0; s_d_valid = 1'b0;
    #1 reset = 1'b1;
    nxt();

    // Single m0 read.
    drv_m(1'b0, 1'b1, 32'h10, 32'h0);
    push_a(1'b0, 32'h10, 32'h0);
    smp();
    chk("t1_m0_a_ready", 64'(m0_a_ready), 64'd1);
    chk("t1_m1_a_ready", 64'(m1_a_ready), 64'd0);
    chk("t1_s_a_valid_early", 64'(s_a_valid), 64'd0);
    nxt();
    m0_a_valid = 1'b0;
    smp();
    check_a("t1_a");
    nxt();
    drv_d(1'b0, 1'b0, 32'hDEADBEEF);
    smp();
    check_d(1'b0, "t1_d", 1'b0);
    chk("t1_s_d_ready", 64'(s_d_ready), 64'd1);
    nxt();
    s_d_valid = 1'b0;
    smp();
    chk("t1_idle_d_valid", 64'(m0_d_valid), 64'd0);

    // Contention from a fresh reset: grants alternate m0, m1, m0, m1.
    nxt();
    reset = 1'b0;
    #2 reset = 1'b1;
    nxt();
    drv_m(1'b0, 1'b1, 32'h100, 32'hA0);
    drv_m(1'b1, 1'b1, 32'h200, 32'hB1);
    for (int t = 0; t < 4; t++) begin
      logic e;
      e = t[0];
      push_a(e, e ? 32'h200 : 32'h100, e ? 32'hB1 : 32'hA0);
      smp();
      chk("ctn_m0_grant", 64'(m0_a_ready), 64'(!e));
      chk("ctn_m1_grant", 64'(m1_a_ready), 64'(e));
      nxt();
      drv_d(e, 1'b0, 32'hC0 + t);
      smp();
      check_a("ctn_a");
      chk("ctn_issue_s_d_ready", 64'(s_d_ready), 64'd0);
      chk("ctn_issue_d_valid", 64'(m0_d_valid | m1_d_valid), 64'd0);
      nxt();
      smp();
      check_d(e, "ctn_d", 1'b0);
      chk("ctn_wait_a_ready", 64'(m0_a_ready | m1_a_ready), 64'd0);
      nxt();
      s_d_valid = 1'b0;
    end

    // Backpressure on s_a_ready for 5 cycles.
    drv_m(1'b1, 1'b0, 32'h0, 32'h0);
    drv_m(1'b0, 1'b1, 32'h300, 32'h55AA);
    s_a_ready = 1'b0;
    push_a(1'b0, 32'h300, 32'h55AA);
    smp();
    chk("bp_grant", 64'(m0_a_ready), 64'd1);
    nxt();
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("bp_hold_valid", 64'(s_a_valid), 64'd1);
      chk("bp_hold_addr", 64'(s_a_address), 64'h300);
      chk("bp_hold_data", 64'(s_a_data), 64'h55AA);
      chk("bp_no_regrant", 64'(m0_a_ready | m1_a_ready), 64'd0);
      nxt();
    end
    s_a_ready = 1'b1;
    smp();
    check_a("bp_a");
    nxt();
    m0_a_valid = 1'b0;
    drv_d(1'b0, 1'b0, 32'h1234);
    smp();
    check_d(1'b0, "bp_d", 1'b0);
    nxt();
    s_d_valid = 1'b0;

    // D stall on m1.
    drv_m(1'b1, 1'b1, 32'h400, 32'h77);
    push_a(1'b1, 32'h400, 32'h77);
    smp();
    chk("ds_grant", 64'(m1_a_ready), 64'd1);
    nxt();
    m1_a_valid = 1'b0;
    smp();
    check_a("ds_a");
    nxt();
    m1_d_ready = 1'b0;
    drv_d(1'b1, 1'b0, 32'hFEED);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("ds_s_d_ready", 64'(s_d_ready), 64'd0);
      chk("ds_still_wait", 64'(m1_d_valid), 64'd1);
      nxt();
    end
    m1_d_ready = 1'b1;
    smp();
    chk("ds_release_ready", 64'(s_d_ready), 64'd1);
    check_d(1'b1, "ds_d", 1'b0);
    nxt();
    s_d_valid = 1'b0;
    smp();
    chk("ds_done", 64'(m1_d_valid), 64'd0);

    // Source mismatch: owner 1, response tagged 0.
    nxt();
    drv_m(1'b1, 1'b1, 32'h500, 32'h99);
    push_a(1'b1, 32'h500, 32'h99);
    smp();
    chk("mm_grant", 64'(m1_a_ready), 64'd1);
    nxt();
    m1_a_valid = 1'b0;
    smp();
    check_a("mm_a");
    nxt();
    drv_d(1'b0, 1'b0, 32'hBAD0);
    s_d_sink = 1'b1;
    smp();
    check_d(1'b1, "mm_d", 1'b1);
    chk("mm_source", 64'(m1_d_source), 64'd0);
    chk("mm_sink", 64'(m1_d_sink), 64'd1);
    nxt();
    s_d_valid = 1'b0; s_d_sink = 1'b0;

    // Async reset while in WAIT_D.
    drv_m(1'b1, 1'b1, 32'h600, 32'h66);
    push_a(1'b1, 32'h600, 32'h66);
    smp();
    chk("rw_grant", 64'(m1_a_ready), 64'd1);
    nxt();
    m1_a_valid = 1'b0;
    smp();
    check_a("rw_a");
    nxt();
    m1_d_ready = 1'b0;
    s_d_valid = 1'b1; s_d_source = 1'b1; s_d_data = 32'h6666;
    drv_m(1'b0, 1'b1, 32'h700, 32'h70);
    smp();
    chk("rw_in_wait", 64'(m1_d_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("rw_s_a_valid", 64'(s_a_valid), 64'd0);
    chk("rw_s_a_addr", 64'(s_a_address), 64'd0);
    chk("rw_s_a_source", 64'(s_a_source), 64'd0);
    chk("rw_m1_d_valid", 64'(m1_d_valid), 64'd0);
    chk("rw_m1_d_data", 64'(m1_d_data), 64'd0);
    chk("rw_s_d_ready", 64'(s_d_ready), 64'd0);
    chk("rw_a_ready", 64'(m0_a_ready | m1_a_ready), 64'd0);
    m0_a_valid = 1'b0; s_d_valid = 1'b0; m1_d_ready = 1'b1;
    drv_m(1'b1, 1'b1, 32'h800, 32'h88);
    push_a(1'b1, 32'h800, 32'h88);
    #1 reset = 1'b1;
    #1;
    chk("rw_regrant", 64'(m1_a_ready), 64'd1);
    nxt();
    m1_a_valid = 1'b0;
    smp();
    check_a("rw_after_a");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
